// File: rtl/disparo_nave_pkg.sv
// Shared definitions for the player-ship shot controller: coordinate type,
// parking coordinate, score ceiling and the shot state encoding.
package disparo_nave_pkg;

  typedef logic [9:0] coord_t;

  // Off-screen coordinate; no enemy box can ever contain it
  localparam coord_t PARK = 10'd1023;

  // Score counter ceiling
  localparam logic [9:0] PLACAR_MAX = 10'd999;

  typedef enum logic [1:0] {
    OCIOSA  = 2'd0,
    VOANDO  = 2'd1,
    RECARGA = 2'd2
  } estado_t;

  // Score increment that sticks at the ceiling instead of wrapping
  function automatic logic [9:0] incrementa_placar(input logic [9:0] placar);
    return (placar >= PLACAR_MAX) ? placar : placar + 10'd1;
  endfunction

endpackage

// File: rtl/disparo_nave_if.sv
// Signal bundle between the game logic and the ship shot controller.
// master = game side driving controls, slave = the shot controller.
interface disparo_nave_if;
  import disparo_nave_pkg::*;

  logic   pausa;
  logic   reiniciarJogo;
  logic   disparo;
  coord_t x_nave;
  coord_t y_nave;
  logic   acerto;
  coord_t x_bola_nave;
  coord_t y_bola_nave;
  logic   bola_ativa;
  logic [9:0] acertos;

  modport master (
    output pausa, reiniciarJogo, disparo, x_nave, y_nave, acerto,
    input  x_bola_nave, y_bola_nave, bola_ativa, acertos
  );

  modport slave (
    input  pausa, reiniciarJogo, disparo, x_nave, y_nave, acerto,
    output x_bola_nave, y_bola_nave, bola_ativa, acertos
  );

endinterface

// File: rtl/disparo_nave_divisor_tick.sv
// Movement tick generator: a one-clock strobe every DIV enabled clocks.
// The counter phase is kept while disabled so a pause resumes mid-period.
module divisor_tick #(
  parameter int DIV = 320000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

  logic [W-1:0] cont;

  // Count 0..DIV-1 while enabled, wrap at the top, clear on game restart
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cont <= '0;
    end else if (clr) begin
      cont <= '0;
    end else if (en) begin
      if (cont == ULTIMO) cont <= '0;
      else                cont <= cont + 1'b1;
    end
  end

  assign tick = en & ~clr & (cont == ULTIMO);

endmodule

// File: rtl/disparo_nave.sv
// Player-ship shot controller: launches a single shot on a fire-button press,
// climbs it PASSO pixels per tick, retires it on a hit or at the top edge,
// then waits RECARGA_TICKS ticks before another shot is allowed.
// Also keeps the saturating enemy-hit score.
module disparo_nave
  import disparo_nave_pkg::*;
#(
  parameter int DIV_TICK      = 320000,
  parameter int PASSO         = 4,
  parameter int LARG_NAVE     = 33,
  parameter int RECARGA_TICKS = 8
) (
  input logic           CLOCK_50,
  input logic           reset,
  disparo_nave_if.slave bus
);

  localparam int RW = $clog2(RECARGA_TICKS + 1);
  localparam logic [RW-1:0] RECARGA_FIM = RW'(RECARGA_TICKS - 1);
  localparam coord_t PASSO_C  = coord_t'(PASSO);
  localparam coord_t OFFSET_X = coord_t'(LARG_NAVE / 2);

  estado_t       estado;
  logic          disparo_q;
  logic          tick;
  logic          fire;
  logic [RW-1:0] cont_recarga;
  coord_t        x_bola;
  coord_t        y_bola;
  logic          bola_ativa_r;
  logic [9:0]    acertos_r;

  divisor_tick #(.DIV(DIV_TICK)) u_divisor (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clr      (bus.reiniciarJogo),
    .en       (!bus.pausa),
    .tick     (tick)
  );

  // Fire-button history; tracks the button even while paused so a press
  // made during a pause is consumed there and never fires afterwards
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                  disparo_q <= 1'b0;
    else if (bus.reiniciarJogo) disparo_q <= 1'b0;
    else                        disparo_q <= bus.disparo;
  end

  assign fire = bus.disparo & ~disparo_q;

  // Shot state machine with registered position, flight flag and score
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSA;
      x_bola       <= PARK;
      y_bola       <= PARK;
      bola_ativa_r <= 1'b0;
      acertos_r    <= '0;
      cont_recarga <= '0;
    end else if (bus.reiniciarJogo) begin
      estado       <= OCIOSA;
      x_bola       <= PARK;
      y_bola       <= PARK;
      bola_ativa_r <= 1'b0;
      acertos_r    <= '0;
      cont_recarga <= '0;
    end else if (!bus.pausa) begin
      unique case (estado)
        OCIOSA: begin
          if (fire) begin
            estado       <= VOANDO;
            x_bola       <= bus.x_nave + OFFSET_X;
            y_bola       <= bus.y_nave;
            bola_ativa_r <= 1'b1;
          end
        end
        VOANDO: begin
          if (bus.acerto) begin
            estado       <= RECARGA;
            x_bola       <= PARK;
            y_bola       <= PARK;
            bola_ativa_r <= 1'b0;
            acertos_r    <= incrementa_placar(acertos_r);
          end else if (tick) begin
            if (y_bola < PASSO_C) begin
              estado       <= RECARGA;
              x_bola       <= PARK;
              y_bola       <= PARK;
              bola_ativa_r <= 1'b0;
            end else begin
              y_bola <= y_bola - PASSO_C;
            end
          end
        end
        RECARGA: begin
          if (tick) begin
            if (cont_recarga == RECARGA_FIM) begin
              estado       <= OCIOSA;
              cont_recarga <= '0;
            end else begin
              cont_recarga <= cont_recarga + 1'b1;
            end
          end
        end
        default: begin
          estado       <= OCIOSA;
          x_bola       <= PARK;
          y_bola       <= PARK;
          bola_ativa_r <= 1'b0;
          cont_recarga <= '0;
        end
      endcase
    end
  end

  assign bus.x_bola_nave = x_bola;
  assign bus.y_bola_nave = y_bola;
  assign bus.bola_ativa  = bola_ativa_r;
  assign bus.acertos     = acertos_r;

endmodule

// File: tb/tb_disparo_nave.sv
// Bench for the ship shot controller: a behavioural model predicts the
// outputs every cycle, and directed scenarios add hand-computed checks.
module tb_disparo_nave;

  localparam int DIV_TICK      = 4;
  localparam int PASSO         = 4;
  localparam int LARG_NAVE     = 33;
  localparam int RECARGA_TICKS = 2;
  localparam int PARK_V        = 1023;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  int checks = 0;
  int errors = 0;

  disparo_nave_if bus ();

  disparo_nave #(
    .DIV_TICK      (DIV_TICK),
    .PASSO         (PASSO),
    .LARG_NAVE     (LARG_NAVE),
    .RECARGA_TICKS (RECARGA_TICKS)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Behavioural model: a shot is either flying at (m_x, m_y), or the gun is
  // reloading with some ticks still to wait, or the gun is ready
  bit m_voando = 0;
  int m_x = 0;
  int m_y = 0;
  int m_espera = 0;
  int m_placar = 0;
  int m_fase = 0;
  bit m_disp_ant = 0;

  function void limpaModelo();
    m_voando   = 0;
    m_espera   = 0;
    m_placar   = 0;
    m_fase     = 0;
    m_disp_ant = 0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge
  always @(posedge CLOCK_50 or posedge reset) begin
    bit tiro;
    bit marca;
    if (reset) begin
      limpaModelo();
    end else if (bus.reiniciarJogo) begin
      limpaModelo();
    end else begin
      if (!bus.pausa) begin
        tiro   = bus.disparo && !m_disp_ant;
        marca  = (m_fase == DIV_TICK - 1);
        m_fase = (m_fase + 1) % DIV_TICK;
        if (m_voando) begin
          if (bus.acerto) begin
            m_voando = 0;
            m_espera = RECARGA_TICKS;
            if (m_placar < 999) m_placar++;
          end else if (marca) begin
            if (m_y < PASSO) begin
              m_voando = 0;
              m_espera = RECARGA_TICKS;
            end else begin
              m_y -= PASSO;
            end
          end
        end else if (m_espera > 0) begin
          if (marca) m_espera--;
        end else if (tiro) begin
          m_voando = 1;
          m_x = (int'(bus.x_nave) + LARG_NAVE / 2) % 1024;
          m_y = int'(bus.y_nave);
        end
      end
      m_disp_ant = bus.disparo;
    end
  end

  task automatic checkOutput(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge CLOCK_50) begin
    checkOutput("model x_bola_nave", int'(bus.x_bola_nave), m_voando ? m_x : PARK_V);
    checkOutput("model y_bola_nave", int'(bus.y_bola_nave), m_voando ? m_y : PARK_V);
    checkOutput("model bola_ativa", int'(bus.bola_ativa), int'(m_voando));
    checkOutput("model acertos", int'(bus.acertos), m_placar);
  end

  task automatic stepClocks(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic applyStimulus(input logic dsp, input logic acc, input logic pau, input logic rein);
    bus.disparo       = dsp;
    bus.acerto        = acc;
    bus.pausa         = pau;
    bus.reiniciarJogo = rein;
    stepClocks(1);
  endtask

  task automatic hitCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepClocks(8);
  endtask

  initial begin
    int y_pausa;
    bit achou;
    bus.pausa         = 1'b0;
    bus.reiniciarJogo = 1'b0;
    bus.disparo       = 1'b0;
    bus.acerto        = 1'b0;
    bus.x_nave        = 10'd100;
    bus.y_nave        = 10'd440;

    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;

    // Idle after reset
    stepClocks(20);
    checkOutput("idle x", int'(bus.x_bola_nave), 1023);
    checkOutput("idle y", int'(bus.y_bola_nave), 1023);
    checkOutput("idle bola_ativa", int'(bus.bola_ativa), 0);
    checkOutput("idle acertos", int'(bus.acertos), 0);

    // Launch from x_nave=100, y_nave=440
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("launch x", int'(bus.x_bola_nave), 116);
    checkOutput("launch y", int'(bus.y_bola_nave), 440);
    checkOutput("launch bola_ativa", int'(bus.bola_ativa), 1);
    bus.x_nave = 10'd300;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepClocks(11);
    checkOutput("3 ticks y", int'(bus.y_bola_nave), 428);
    checkOutput("3 ticks x fixed", int'(bus.x_bola_nave), 116);

    // Let the shot run off the top and reload
    stepClocks(4 * 110 + 16);
    checkOutput("top exit bola_ativa", int'(bus.bola_ativa), 0);
    checkOutput("top exit acertos", int'(bus.acertos), 0);

    // Shot at y=2 on a tick is parked without scoring
    bus.y_nave = 10'd6;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("low launch y", int'(bus.y_bola_nave), 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepClocks(7);
    checkOutput("top edge x parked", int'(bus.x_bola_nave), 1023);
    checkOutput("top edge y parked", int'(bus.y_bola_nave), 1023);
    checkOutput("top edge acertos", int'(bus.acertos), 0);
    stepClocks(8);
    bus.y_nave = 10'd440;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("relaunch after top x", int'(bus.x_bola_nave), 316);
    checkOutput("relaunch after top bola", int'(bus.bola_ativa), 1);

    // Hit during flight, fire during reload ignored, fire after reload works
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("hit acertos", int'(bus.acertos), 1);
    checkOutput("hit y parked", int'(bus.y_bola_nave), 1023);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fire in reload bola", int'(bus.bola_ativa), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepClocks(8);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fire after reload bola", int'(bus.bola_ativa), 1);
    checkOutput("fire after reload y", int'(bus.y_bola_nave), 440);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Hit and tick on the same clock: scored and parked
    achou = 0;
    for (int i = 0; i < 2 * DIV_TICK && !achou; i++) begin
      if (m_fase == DIV_TICK - 1) achou = 1;
      else stepClocks(1);
    end
    checkOutput("tick phase found", int'(achou), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("hit+tick acertos", int'(bus.acertos), 2);
    checkOutput("hit+tick x parked", int'(bus.x_bola_nave), 1023);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepClocks(8);

    // Drive the score to its ceiling, then one more hit
    for (int i = 0; i < 997; i++) hitCycle();
    checkOutput("score at 999", int'(bus.acertos), 999);
    hitCycle();
    checkOutput("score saturated", int'(bus.acertos), 999);

    // Pause mid-flight with button and hit activity
    bus.x_nave = 10'd100;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    y_pausa = m_y;
    for (int i = 0; i < 50; i++)
      applyStimulus(logic'(i % 2), logic'(i % 5 == 0), 1'b1, 1'b0);
    checkOutput("pause y frozen", int'(bus.y_bola_nave), y_pausa);
    checkOutput("pause bola_ativa", int'(bus.bola_ativa), 1);
    checkOutput("pause acertos", int'(bus.acertos), 999);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepClocks(8);
    checkOutput("resume x", int'(bus.x_bola_nave), 116);

    // Asynchronous reset mid-flight
    #1 reset = 1'b1;
    #1;
    checkOutput("async reset x", int'(bus.x_bola_nave), 1023);
    checkOutput("async reset bola", int'(bus.bola_ativa), 0);
    checkOutput("async reset acertos", int'(bus.acertos), 0);
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    stepClocks(2);

    // Score one hit, relaunch, then synchronous restart mid-flight
    hitCycle();
    checkOutput("pre-restart acertos", int'(bus.acertos), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pre-restart bola", int'(bus.bola_ativa), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("restart y", int'(bus.y_bola_nave), 1023);
    checkOutput("restart bola", int'(bus.bola_ativa), 0);
    checkOutput("restart acertos", int'(bus.acertos), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepClocks(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
